uart_hex_formatter: RTL and testbench

UART_HEX_FORMATTER -- requirements
Module: uart_hex_formatter

---
 rtl/uart_hex_formatter.sv | 142 ++++++++++++++
 tb/tb_uart_hex_formatter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_formatter.sv
// rtl/uart_hex_formatter.sv - formats a word as an ASCII hex message for a UART transmitter
// Each message is an optional "0x", the digits MSB nibble first, then an optional CR LF.
module uart_hex_formatter #(
   parameter int NIBBLES = 8,
   parameter bit PREFIX  = 1'b1,
   parameter bit NEWLINE = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4*NIBBLES-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_data_valid,
   input  logic                 tx_data_ready,
   output logic                 busy
);

   localparam int              CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0]   CNT_TOP = CW'(NIBBLES - 1);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PFX0 = 3'd1,
      PFX1 = 3'd2,
      HEX  = 3'd3,
      CR   = 3'd4,
      LF   = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [4*NIBBLES-1:0] word_q, word_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 out_hs;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [3:0] nibble_at(input logic [4*NIBBLES-1:0] w,
                                            input logic [CW-1:0]        idx);
      logic [4*NIBBLES-1:0] shifted;
      shifted = w >> {idx, 2'b00};
      return shifted[3:0];
   endfunction

   assign out_hs = tx_valid_q && tx_data_ready;

   // state_q names the byte currently presented on tx_data, so every
   // transition loads the byte that the new state stands for.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      case (state_q)
         IDLE: begin
            tx_valid_d = 1'b0;
            if (in_valid) begin
               word_d     = in_data;
               cnt_d      = CNT_TOP;
               tx_valid_d = 1'b1;
               if (PREFIX) begin
                  state_d   = PFX0;
                  tx_data_d = 8'h30;
               end else begin
                  state_d   = HEX;
                  tx_data_d = hex_ascii(nibble_at(in_data, CNT_TOP));
               end
            end
         end
         PFX0: begin
            if (out_hs) begin
               state_d   = PFX1;
               tx_data_d = 8'h78;
            end
         end
         PFX1: begin
            if (out_hs) begin
               state_d   = HEX;
               tx_data_d = hex_ascii(nibble_at(word_q, cnt_q));
            end
         end
         HEX: begin
            if (out_hs) begin
               if (cnt_q != '0) begin
                  cnt_d     = cnt_q - CNT_ONE;
                  tx_data_d = hex_ascii(nibble_at(word_q, cnt_q - CNT_ONE));
               end else if (NEWLINE) begin
                  state_d   = CR;
                  tx_data_d = 8'h0D;
               end else begin
                  state_d    = IDLE;
                  tx_valid_d = 1'b0;
               end
            end
         end
         CR: begin
            if (out_hs) begin
               state_d   = LF;
               tx_data_d = 8'h0A;
            end
         end
         LF: begin
            if (out_hs) begin
               state_d    = IDLE;
               tx_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         word_q     <= '0;
         cnt_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign tx_data       = tx_data_q;
   assign tx_data_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_hex_formatter.sv
// tb/tb_uart_hex_formatter.sv - randomized self-checking bench for uart_hex_formatter
`timescale 1ns/1ps
module tb_uart_hex_formatter;

   typedef logic [7:0] bq_t [$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  tx_data;
   logic        tx_data_valid;
   logic        tx_data_ready;
   logic        busy;

   logic [7:0]  b_in_data;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [7:0]  b_tx_data;
   logic        b_tx_data_valid;
   logic        b_tx_data_ready;
   logic        b_busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_hex_formatter dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
      .busy(busy)
   );

   uart_hex_formatter #(.NIBBLES(2), .PREFIX(1'b0), .NEWLINE(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .tx_data(b_tx_data), .tx_data_valid(b_tx_data_valid), .tx_data_ready(b_tx_data_ready),
      .busy(b_busy)
   );

   // Reference: the message as text, built from the formatting rules directly.
   function automatic bq_t model_msg(input logic [63:0] word, input int nib, input bit pfx, input bit nl);
      bq_t q;
      int  d;
      q = {};
      if (pfx) begin
         q.push_back(8'h30);
         q.push_back(8'h78);
      end
      for (int i = nib - 1; i >= 0; i--) begin
         d = int'((word >> (4 * i)) & 64'hF);
         q.push_back(d < 10 ? 8'(48 + d) : 8'(65 + d - 10));
      end
      if (nl) begin
         q.push_back(8'h0D);
         q.push_back(8'h0A);
      end
      return q;
   endfunction

   // Drives one word into dut and records accepted bytes; caller is positioned at a negedge.
   task automatic run_msg(input logic [31:0] word, input int mode, input bit hold,
                          input logic [31:0] next_word, output bq_t got, output int wait_cyc,
                          output int lat, output int proto_err, output bit timeout);
      int         hs_cyc;
      int         k;
      int         idx;
      bit         stalled;
      logic [7:0] held;
      got = {}; wait_cyc = 0; lat = 0; proto_err = 0; timeout = 0; stalled = 0; held = 8'h00;
      in_data  = word;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (in_ready !== 1'b1) begin
         in_valid = 1'b0;
         timeout  = 1;
         return;
      end
      hs_cyc = cyc;
      k = 0;
      forever begin
         @(negedge clk);
         k++;
         if (stalled) begin
            if (!(tx_data_valid === 1'b1 && tx_data === held)) proto_err++;
            stalled = 0;
         end
         if (in_ready === 1'b1) begin
            if (tx_data_valid !== 1'b0) proto_err++;
            lat = cyc - hs_cyc;
            if (hold) begin
               in_valid = 1'b1;
               in_data  = next_word;
            end else begin
               in_valid = 1'b0;
            end
            break;
         end
         if (k > 300) begin
            timeout  = 1;
            in_valid = 1'b0;
            break;
         end
         idx = (k - 1) % 4;
         case (mode)
            0:       tx_data_ready = 1'b1;
            1:       tx_data_ready = (idx == 0 || idx == 3);
            default: tx_data_ready = 1'($urandom_range(0, 1));
         endcase
         if (hold) begin
            in_valid = 1'b1;
            in_data  = next_word;
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
         end
         if (tx_data_valid === 1'b1) begin
            if (tx_data_ready) got.push_back(tx_data);
            else begin
               stalled = 1;
               held    = tx_data;
            end
         end else begin
            proto_err++;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tx_data_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_tx_data_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_data_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
      checks++; if (b_in_ready !== 1'b1 || b_tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_b: got ready %b valid %b expected 1 0", b_in_ready, b_tx_data_valid); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      bq_t got, exp;
      int  w, lat, perr;
      bit  to;
      exp = model_msg(64'h1234ABCD, 8, 1, 1);
      @(negedge clk);
      run_msg(32'h1234ABCD, 0, 0, 32'h0, got, w, lat, perr, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected 0", to); end
      checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL basic_len: got %0d expected %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, got[i], exp[i]); end
      end
      checks++; if (lat != 13) begin errors++; $display("FAIL basic_ready_latency: got %0d expected 13", lat); end
      checks++; if (perr != 0) begin errors++; $display("FAIL basic_protocol: got %0d errors expected 0", perr); end
   endtask

   task automatic test_stall;
      bq_t got, exp;
      int  w, lat, perr;
      bit  to;
      exp = model_msg(64'h0, 8, 1, 1);
      @(negedge clk);
      run_msg(32'h00000000, 1, 0, 32'h0, got, w, lat, perr, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %b expected 0", to); end
      checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL stall_len: got %0d expected %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], exp[i]); end
      end
      checks++; if (perr != 0) begin errors++; $display("FAIL stall_hold_stable: got %0d errors expected 0", perr); end
   endtask

   task automatic test_random;
      bq_t         got, exp;
      int          w, lat, perr;
      bit          to;
      logic [31:0] word;
      for (int n = 0; n < 6; n++) begin
         word = $urandom;
         exp  = model_msg({32'h0, word}, 8, 1, 1);
         @(negedge clk);
         run_msg(word, 2, 0, 32'h0, got, w, lat, perr, to);
         checks++; if (to !== 1'b0 || got.size() != exp.size()) begin errors++; $display("FAIL random%0d_len: got %0d timeout %b expected %0d", n, got.size(), to, exp.size()); end
         for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL random%0d_byte%0d: got %h expected %h", n, i, got[i], exp[i]); end
         end
         checks++; if (perr != 0) begin errors++; $display("FAIL random%0d_protocol: got %0d errors expected 0", n, perr); end
      end
   endtask

   task automatic test_back_to_back;
      bq_t got1, got2, exp1, exp2;
      int  w1, w2, lat1, lat2, p1, p2;
      bit  to1, to2;
      exp1 = model_msg(64'hDEADBEEF, 8, 1, 1);
      exp2 = model_msg(64'h00000009, 8, 1, 1);
      @(negedge clk);
      run_msg(32'hDEADBEEF, 0, 1, 32'h00000009, got1, w1, lat1, p1, to1);
      run_msg(32'h00000009, 0, 0, 32'h0, got2, w2, lat2, p2, to2);
      checks++; if (lat1 != 13 || to1) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 13", lat1); end
      checks++; if (w2 != 0 || to2) begin errors++; $display("FAIL b2b_second_accept_wait: got %0d expected 0", w2); end
      checks++; if (got1.size() != exp1.size() || got2.size() != exp2.size()) begin errors++; $display("FAIL b2b_len: got %0d/%0d expected %0d/%0d", got1.size(), got2.size(), exp1.size(), exp2.size()); end
      for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
         checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL b2b_first_byte%0d: got %h expected %h", i, got1[i], exp1[i]); end
      end
      for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
         checks++; if (got2[i] !== exp2[i]) begin errors++; $display("FAIL b2b_second_byte%0d: got %h expected %h", i, got2[i], exp2[i]); end
      end
   endtask

   task automatic test_reset_mid;
      bq_t         got, exp_old, exp;
      int          n, w, lat, perr;
      bit          to;
      logic [31:0] word;
      exp_old = model_msg(64'hCAFEF00D, 8, 1, 1);
      got = {};
      n = 0;
      @(negedge clk);
      tx_data_ready = 1'b1;
      in_data  = 32'hCAFEF00D;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 50 && n < 5; i++) begin
         if (tx_data_valid === 1'b1) begin
            got.push_back(tx_data);
            n++;
         end
         @(negedge clk);
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_old[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, got[i], exp_old[i]); end
      end
      rst_n = 1'b0;
      #1;
      checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid: got %b expected 0", tx_data_valid); end
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got ready %b busy %b expected 1 0", in_ready, busy); end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      word = $urandom;
      exp  = model_msg({32'h0, word}, 8, 1, 1);
      @(negedge clk);
      run_msg(word, 0, 0, 32'h0, got, w, lat, perr, to);
      checks++; if (w != 0 || to) begin errors++; $display("FAIL rstmid_first_accept: got wait %0d expected 0", w); end
      checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL rstmid_new_len: got %0d expected %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rstmid_new_byte%0d: got %h expected %h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_small_config;
      bq_t        got, exp;
      int         busy_cnt;
      logic [7:0] word;
      for (int n = 0; n < 4; n++) begin
         word = (n == 0) ? 8'hF0 : 8'($urandom);
         exp  = model_msg({56'h0, word}, 2, 0, 0);
         got = {};
         busy_cnt = 0;
         @(negedge clk);
         checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL small%0d_ready: got %b expected 1", n, b_in_ready); end
         b_in_data  = word;
         b_in_valid = 1'b1;
         @(negedge clk);
         b_in_valid = 1'b0;
         b_in_data  = 8'($urandom);
         for (int i = 0; i < 8; i++) begin
            if (b_busy === 1'b1) busy_cnt++;
            if (b_tx_data_valid === 1'b1) got.push_back(b_tx_data);
            @(negedge clk);
         end
         checks++; if (busy_cnt != 2) begin errors++; $display("FAIL small%0d_busy_cycles: got %0d expected 2", n, busy_cnt); end
         checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL small%0d_len: got %0d expected %0d", n, got.size(), exp.size()); end
         for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL small%0d_byte%0d: got %h expected %h", n, i, got[i], exp[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_small_config();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
